// File: rtl/pc_sequencer_if.sv
// ----------------------------------------------------------------------------
// pc_sequencer_if
// Connects the ForthCPU program-counter sequencer to the rest of the core.
//
// Signals (named from the sequencer's point of view):
//   pc_basex, pc_offsetx : next-PC base/offset selects from the branch logic
//   a_reg, din           : base register operand and offset/target from datapath
//   exec_done, reti      : execute stage finished / return from interrupt
//   int_req              : level interrupt request
//   fetch_ack, fetch_data: memory returns an instruction word
//   pc, fetch_req        : program counter and fetch request (address = pc)
//   instr, instr_valid   : latched instruction and execute enable
//   int_ack, ie, ret_pc  : interrupt entry pulse, enable flag, saved return address
//
// Modports: slave = sequencer, master = core / memory side.
// ----------------------------------------------------------------------------
interface pc_sequencer_if #(
    parameter int unsigned WIDTH = 16
);
    logic [1:0]       pc_basex;
    logic [1:0]       pc_offsetx;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] din;
    logic             exec_done;
    logic             reti;
    logic             int_req;
    logic             fetch_ack;
    logic [WIDTH-1:0] fetch_data;

    logic [WIDTH-1:0] pc;
    logic             fetch_req;
    logic [WIDTH-1:0] instr;
    logic             instr_valid;
    logic             int_ack;
    logic             ie;
    logic [WIDTH-1:0] ret_pc;

    modport slave (
        input  pc_basex, pc_offsetx, a_reg, din, exec_done, reti, int_req,
               fetch_ack, fetch_data,
        output pc, fetch_req, instr, instr_valid, int_ack, ie, ret_pc
    );

    modport master (
        output pc_basex, pc_offsetx, a_reg, din, exec_done, reti, int_req,
               fetch_ack, fetch_data,
        input  pc, fetch_req, instr, instr_valid, int_ack, ie, ret_pc
    );
endinterface

// File: rtl/pc_sequencer.sv
// ----------------------------------------------------------------------------
// pc_sequencer
// Owns the ForthCPU program counter and the fetch/execute sequence:
//   BOOT -> FETCH -> EXEC -> (INT ->) FETCH ...
// An instruction is fetched at PC and held while execute runs. When execute
// completes, PC is updated from the branch selects (or restored from RET_PC on
// RETI). A single-level interrupt is taken at execute completion if IE is set;
// the interrupt cycle saves the already-updated PC and jumps to INT_VECTOR.
//
// Ports:
//   clk_i  : system clock, rising edge
//   rst_i  : asynchronous active-high reset
//   bus_io : pc_sequencer_if slave modport (selects, operands, handshakes,
//            PC / instruction / interrupt outputs)
//
// PC, INSTR, IE and RET_PC are registered; FETCH_REQ, INSTR_VALID and INT_ACK
// decode directly from the state register.
// ----------------------------------------------------------------------------
module pc_sequencer #(
    parameter int unsigned      WIDTH        = 16,
    parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(16'h0000),
    parameter logic [WIDTH-1:0] INT_VECTOR   = WIDTH'(16'h0004)
) (
    input  logic           clk_i,
    input  logic           rst_i,
    pc_sequencer_if.slave  bus_io
);

    typedef enum logic [1:0] {
        StBoot,
        StFetch,
        StExec,
        StInt
    } state_e;

    state_e           state_q;
    logic [WIDTH-1:0] pc_q;
    logic [WIDTH-1:0] instr_q;
    logic [WIDTH-1:0] ret_pc_q;
    logic             ie_q;

    // Values committed at the EXEC_DONE edge
    logic [WIDTH-1:0] base;
    logic [WIDTH-1:0] offset;
    logic [WIDTH-1:0] target;
    logic [WIDTH-1:0] pc_d;
    logic             ie_d;
    logic             take_int;

    // ------------------------------------------------------------------------
    // Next-PC selection. Reserved select codes (11) alias the documented
    // defaults: base PC, offset 2.
    // ------------------------------------------------------------------------
    always_comb begin
        base = pc_q;
        unique case (bus_io.pc_basex)
            2'b00:   base = pc_q;
            2'b01:   base = '0;
            2'b10:   base = bus_io.a_reg;
            2'b11:   base = pc_q;
            default: base = pc_q;
        endcase

        offset = '0;
        unique case (bus_io.pc_offsetx)
            2'b00:   offset = '0;
            2'b01:   offset = WIDTH'(2);
            2'b10:   offset = bus_io.din;
            2'b11:   offset = WIDTH'(2);
            default: offset = '0;
        endcase

        // Wraps modulo 2^WIDTH; instructions are halfword aligned
        target = base + offset;
    end

    always_comb begin
        pc_d = {target[WIDTH-1:1], 1'b0};
        ie_d = ie_q;
        if (bus_io.reti) begin
            pc_d = ret_pc_q;
            ie_d = 1'b1;
        end
        // RETI re-enables first, so a pending request is taken straight away
        take_int = bus_io.int_req & ie_d;
    end

    // ------------------------------------------------------------------------
    // Sequencer state and registered outputs
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= StBoot;
            pc_q     <= RESET_VECTOR;
            instr_q  <= '0;
            ret_pc_q <= '0;
            ie_q     <= 1'b1;
        end else begin
            unique case (state_q)
                StBoot: begin
                    state_q <= StFetch;
                end

                StFetch: begin
                    if (bus_io.fetch_ack) begin
                        instr_q <= bus_io.fetch_data;
                        state_q <= StExec;
                    end
                end

                StExec: begin
                    if (bus_io.exec_done) begin
                        pc_q    <= pc_d;
                        ie_q    <= ie_d;
                        state_q <= take_int ? StInt : StFetch;
                    end
                end

                StInt: begin
                    // pc_q already holds the post-execute target here
                    ret_pc_q <= pc_q;
                    pc_q     <= INT_VECTOR;
                    ie_q     <= 1'b0;
                    state_q  <= StFetch;
                end

                default: begin
                    state_q <= StBoot;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign bus_io.pc          = pc_q;
    assign bus_io.instr       = instr_q;
    assign bus_io.ret_pc      = ret_pc_q;
    assign bus_io.ie          = ie_q;
    assign bus_io.fetch_req   = (state_q == StFetch);
    assign bus_io.instr_valid = (state_q == StExec);
    assign bus_io.int_ack     = (state_q == StInt);

endmodule
